wb_fwd_history: RTL

WB_FWD_HISTORY -- requirements
Module: wb_fwd_history

---
 rtl/wb_fwd_pkg.sv | 13 +
 rtl/wb_fwd_match.sv | 23 ++
 rtl/wb_fwd_history.sv | 69 ++++++
 3 files changed

// File: rtl/wb_fwd_pkg.sv
// wb_fwd_pkg: default parameters and the history entry record shared by the forwarding block.
package wb_fwd_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;
    localparam int DEPTH_DEF  = 2;
    localparam int NUM_RD_DEF = 2;
    localparam int BYPASS_DEF = 1;
    typedef struct packed {
        logic                  valid;
        logic [REG_AW_DEF-1:0] rg;
        logic [DATA_W_DEF-1:0] data;
    } entry_t;
endpackage

// File: rtl/wb_fwd_match.sv
// wb_fwd_match: picks the highest-priority valid producer for one lookup port; candidate 0 wins.
module wb_fwd_match #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int NC     = 3
) (
    input  logic [NC-1:0]        cand_v,
    input  logic [NC*REG_AW-1:0] cand_r,
    input  logic [NC*DATA_W-1:0] cand_d,
    input  logic [REG_AW-1:0]    addr,
    output logic                 hit,
    output logic [DATA_W-1:0]    data
);
    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = NC - 1; i >= 0; i--)
            if (addr != '0 && cand_v[i] && cand_r[i*REG_AW +: REG_AW] == addr) begin
                hit  = 1'b1;
                data = cand_d[i*DATA_W +: DATA_W];
            end
    end
endmodule

// File: rtl/wb_fwd_history.sv
// wb_fwd_history: write-back history shift register with combinational per-port forwarding.
module wb_fwd_history
    import wb_fwd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int NUM_RD = NUM_RD_DEF,
    parameter int BYPASS = BYPASS_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     RegWrite,
    input  logic [DATA_W-1:0]        write_back_data,
    input  logic [REG_AW-1:0]        write_reg,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [NUM_RD*REG_AW-1:0] rd_addr,
    output logic [NUM_RD-1:0]        fwd_hit,
    output logic [NUM_RD*DATA_W-1:0] fwd_data,
    output logic                     RegWrite_out,
    output logic [DATA_W-1:0]        write_back_data_out,
    output logic [REG_AW-1:0]        write_reg_out
);
    localparam int NC = DEPTH + 1;
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rg;
        logic [DATA_W-1:0] data;
    } hist_t;
    hist_t [DEPTH-1:0]    hist_q, hist_d;
    logic [NC-1:0]        cand_v;
    logic [NC*REG_AW-1:0] cand_r;
    logic [NC*DATA_W-1:0] cand_d;
    always_comb begin
        hist_d = hist_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) hist_d[i].valid = 1'b0;
        end else if (!stall) begin
            hist_d[0] = '{RegWrite, write_reg, write_back_data};
            for (int i = 1; i < DEPTH; i++) hist_d[i] = hist_q[i-1];
        end
    end
    always_ff @(posedge clk) hist_q <= reset ? '0 : hist_d;
    // Slot 0 is the live write-back; it stays eligible during flush but not while stalled.
    always_comb begin
        cand_v[0]            = (BYPASS != 0) && RegWrite && !stall;
        cand_r[REG_AW-1:0]   = write_reg;
        cand_d[DATA_W-1:0]   = write_back_data;
        for (int i = 0; i < DEPTH; i++) begin
            cand_v[i+1]                     = hist_q[i].valid;
            cand_r[(i+1)*REG_AW +: REG_AW]  = hist_q[i].rg;
            cand_d[(i+1)*DATA_W +: DATA_W]  = hist_q[i].data;
        end
    end
    for (genvar p = 0; p < NUM_RD; p++) begin : g_port
        wb_fwd_match #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NC(NC)) u_match (
            .cand_v(cand_v),
            .cand_r(cand_r),
            .cand_d(cand_d),
            .addr  (rd_addr[p*REG_AW +: REG_AW]),
            .hit   (fwd_hit[p]),
            .data  (fwd_data[p*DATA_W +: DATA_W])
        );
    end
    assign RegWrite_out        = hist_q[0].valid;
    assign write_back_data_out = hist_q[0].data;
    assign write_reg_out       = hist_q[0].rg;
endmodule
